// File: rtl/tt_uio_arbiter_pkg.sv
// Shared types and defaults for the user I/O bus arbiter.
package tt_uio_arb_pkg;

    // Bus ownership states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_TURN = 2'd3
    } arb_state_e;

    // Index of a requesting port (0 or 1)
    typedef logic port_idx_t;

    localparam int DEFAULT_TURN_CYCLES = 1;
    localparam int DEFAULT_MAX_HOLD    = 16;

    // Pick the next owner from the effective requests.
    // On a tie the port that was not served last wins.
    function automatic arb_state_e arbitrate(input logic [1:0] r, input port_idx_t last);
        arb_state_e nxt;
        case (r)
            2'b01:   nxt = ST_OWN0;
            2'b10:   nxt = ST_OWN1;
            2'b11:   nxt = (last == 1'b1) ? ST_OWN0 : ST_OWN1;
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tt_uio_arbiter_hold_timer.sv
// Clear/enable up-counter with a terminal-count flag. The counter stops at
// the terminal value so the flag stays asserted until the next clear.
module tt_uio_hold_timer #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign done = (count_q == TERM);

    // Next count: clear wins, otherwise count up until the terminal value
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && !done) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tt_uio_arbiter.sv
// Round-robin owner of the shared 8-bit user I/O bus with an all-inputs
// turnaround gap between two ownerships.
module tt_uio_arbiter
    import tt_uio_arb_pkg::*;
#(
    parameter int TURN_CYCLES = DEFAULT_TURN_CYCLES,
    parameter int MAX_HOLD    = DEFAULT_MAX_HOLD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic [7:0] dout0,
    input  logic [7:0] dout1,
    input  logic [7:0] oe0,
    input  logic [7:0] oe1,
    output logic [7:0] din,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam int TURN_W = 3;

    arb_state_e state_q;
    arb_state_e state_d;
    port_idx_t  last_q;
    port_idx_t  last_d;
    logic [1:0] gnt_q;
    logic [1:0] gnt_d;

    logic [1:0] r;
    logic       in_own;
    logic       in_turn;
    logic       hold_done;
    logic       turn_done;

    assign r       = req & {2{ena}};
    assign in_own  = (state_q == ST_OWN0) || (state_q == ST_OWN1);
    assign in_turn = (state_q == ST_TURN);
    assign din     = uio_in;
    assign gnt     = gnt_q;

    // The hold count saturates, so an owner that has already held the bus
    // for MAX_HOLD cycles alone yields as soon as the other port asks.
    tt_uio_hold_timer #(
        .WIDTH    (HOLD_W),
        .TERMINAL (MAX_HOLD - 1)
    ) u_hold_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!in_own),
        .en    (in_own),
        .done  (hold_done)
    );

    tt_uio_hold_timer #(
        .WIDTH    (TURN_W),
        .TERMINAL (TURN_CYCLES - 1)
    ) u_turn_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!in_turn),
        .en    (in_turn),
        .done  (turn_done)
    );

    // Next-state, round-robin pointer and next grant
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                state_d = arbitrate(r, last_q);
            end
            ST_OWN0: begin
                if (!r[0] || (hold_done && r[1])) begin
                    state_d = ST_TURN;
                    last_d  = 1'b0;
                end
            end
            ST_OWN1: begin
                if (!r[1] || (hold_done && r[0])) begin
                    state_d = ST_TURN;
                    last_d  = 1'b1;
                end
            end
            ST_TURN: begin
                if (turn_done) begin
                    state_d = arbitrate(r, last_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        gnt_d = {state_d == ST_OWN1, state_d == ST_OWN0};
    end

    // State, pointer and grant registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
        end
    end

    // Pad mux: only the current owner drives, everything else is released
    always_comb begin
        uio_out = 8'h00;
        uio_oe  = 8'h00;
        if (gnt_q[0]) begin
            uio_out = dout0;
            uio_oe  = oe0;
        end else if (gnt_q[1]) begin
            uio_out = dout1;
            uio_oe  = oe1;
        end
    end

endmodule

// File: tb/tb_tt_uio_arbiter.sv
// Directed bench for tt_uio_arbiter with default TURN_CYCLES=1, MAX_HOLD=16.
module tb_tt_uio_arbiter;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [7:0] dout0;
    logic [7:0] dout1;
    logic [7:0] oe0;
    logic [7:0] oe1;
    logic [7:0] din;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int errors;

    typedef struct {
        logic [1:0] req;
        logic       ena;
        logic [7:0] dout0;
        logic [7:0] oe0;
        logic [7:0] dout1;
        logic [7:0] oe1;
        logic [7:0] uio_in;
        logic [1:0] exp_gnt;
        logic [7:0] exp_out;
        logic [7:0] exp_oe;
    } vec_t;

    vec_t vecs[16];

    tt_uio_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .req     (req),
        .gnt     (gnt),
        .dout0   (dout0),
        .dout1   (dout1),
        .oe0     (oe0),
        .oe1     (oe1),
        .din     (din),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected pad data for a given grant, built from what the bench drives
    function automatic logic [7:0] modelOut(input logic [1:0] g);
        if (g == 2'b01) return dout0;
        if (g == 2'b10) return dout1;
        return 8'h00;
    endfunction

    function automatic logic [7:0] modelOe(input logic [1:0] g);
        if (g == 2'b01) return oe0;
        if (g == 2'b10) return oe1;
        return 8'h00;
    endfunction

    task automatic applyStimulus(input logic [1:0] r, input logic e,
                                 input logic [7:0] d0, input logic [7:0] o0,
                                 input logic [7:0] d1, input logic [7:0] o1,
                                 input logic [7:0] ui);
        req    = r;
        ena    = e;
        dout0  = d0;
        oe0    = o0;
        dout1  = d1;
        oe1    = o1;
        uio_in = ui;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] exp_gnt,
                               input logic [7:0] exp_out, input logic [7:0] exp_oe,
                               input logic [7:0] exp_din);
        checks++;
        if (gnt !== exp_gnt) begin
            errors++;
            $display("[TB] FAIL %s gnt got %b want %b", name, gnt, exp_gnt);
        end
        checks++;
        if (uio_out !== exp_out) begin
            errors++;
            $display("[TB] FAIL %s uio_out got %h want %h", name, uio_out, exp_out);
        end
        checks++;
        if (uio_oe !== exp_oe) begin
            errors++;
            $display("[TB] FAIL %s uio_oe got %h want %h", name, uio_oe, exp_oe);
        end
        checks++;
        if (din !== exp_din) begin
            errors++;
            $display("[TB] FAIL %s din got %h want %h", name, din, exp_din);
        end
    endtask

    // One clock with the given request; data inputs stay as they are
    task automatic step(input string name, input logic [1:0] r, input logic [1:0] exp_gnt);
        req = r;
        @(posedge clk);
        #1;
        checkOutput(name, exp_gnt, modelOut(exp_gnt), modelOe(exp_gnt), uio_in);
    endtask

    task automatic pulseReset();
        req   = 2'b00;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{2'b10, 1'b1, 8'h11, 8'h0F, 8'hA5, 8'hF0, 8'h3C, 2'b10, 8'hA5, 8'hF0};
        vecs[1]  = '{2'b10, 1'b1, 8'h11, 8'h0F, 8'h5A, 8'hF0, 8'hC3, 2'b10, 8'h5A, 8'hF0};
        vecs[2]  = '{2'b11, 1'b1, 8'h11, 8'h0F, 8'h5A, 8'hF0, 8'h00, 2'b10, 8'h5A, 8'hF0};
        vecs[3]  = '{2'b01, 1'b1, 8'h11, 8'h0F, 8'h5A, 8'hF0, 8'hFF, 2'b00, 8'h00, 8'h00};
        vecs[4]  = '{2'b01, 1'b1, 8'h11, 8'h0F, 8'h5A, 8'hF0, 8'h81, 2'b01, 8'h11, 8'h0F};
        vecs[5]  = '{2'b00, 1'b1, 8'h11, 8'h0F, 8'h5A, 8'hF0, 8'h18, 2'b00, 8'h00, 8'h00};
        vecs[6]  = '{2'b00, 1'b1, 8'h11, 8'h0F, 8'h5A, 8'hF0, 8'h24, 2'b00, 8'h00, 8'h00};
        vecs[7]  = '{2'b11, 1'b1, 8'h11, 8'h0F, 8'h5A, 8'hF0, 8'h42, 2'b10, 8'h5A, 8'hF0};
        vecs[8]  = '{2'b11, 1'b0, 8'h11, 8'h0F, 8'h5A, 8'hF0, 8'h99, 2'b00, 8'h00, 8'h00};
        vecs[9]  = '{2'b11, 1'b0, 8'h11, 8'h0F, 8'h5A, 8'hF0, 8'h66, 2'b00, 8'h00, 8'h00};
        vecs[10] = '{2'b11, 1'b0, 8'h11, 8'h0F, 8'h5A, 8'hF0, 8'h55, 2'b00, 8'h00, 8'h00};
        vecs[11] = '{2'b11, 1'b1, 8'h11, 8'h0F, 8'h5A, 8'hF0, 8'hAA, 2'b01, 8'h11, 8'h0F};
        vecs[12] = '{2'b01, 1'b1, 8'h77, 8'hFF, 8'h5A, 8'hF0, 8'h01, 2'b01, 8'h77, 8'hFF};
        vecs[13] = '{2'b00, 1'b1, 8'h77, 8'hFF, 8'h5A, 8'hF0, 8'h02, 2'b00, 8'h00, 8'h00};
        vecs[14] = '{2'b10, 1'b1, 8'h77, 8'hFF, 8'h5A, 8'hF0, 8'h04, 2'b10, 8'h5A, 8'hF0};
        vecs[15] = '{2'b00, 1'b1, 8'h77, 8'hFF, 8'h5A, 8'hF0, 8'h08, 2'b00, 8'h00, 8'h00};

        // Reset held with both ports requesting and driving enables
        applyStimulus(2'b11, 1'b1, 8'h11, 8'h0F, 8'hA5, 8'hF0, 8'h3C);
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("reset%0d", i), 2'b00, 8'h00, 8'h00, 8'h3C);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_release", 2'b01, 8'h11, 8'h0F, 8'h3C);

        // Table of single-cycle vectors starting from a fresh reset
        pulseReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].req, vecs[i].ena, vecs[i].dout0, vecs[i].oe0,
                          vecs[i].dout1, vecs[i].oe1, vecs[i].uio_in);
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_gnt, vecs[i].exp_out,
                        vecs[i].exp_oe, vecs[i].uio_in);
        end

        // Tie round-robin: each owner releases after three cycles, re-raises in TURN
        applyStimulus(2'b00, 1'b1, 8'h21, 8'h3F, 8'hB4, 8'hFC, 8'h7E);
        pulseReset();
        for (int rnd = 0; rnd < 4; rnd++) begin
            logic [1:0] own;
            own = (rnd % 2 == 0) ? 2'b01 : 2'b10;
            for (int c = 0; c < 3; c++) begin
                step($sformatf("rr%0d_own%0d", rnd, c), 2'b11, own);
            end
            step($sformatf("rr%0d_turn", rnd), 2'b11 & ~own, 2'b00);
        end

        // Preemption: each port keeps the bus exactly 16 cycles while the other waits
        pulseReset();
        for (int c = 0; c < 16; c++) begin
            step($sformatf("pre0_%0d", c), 2'b11, 2'b01);
        end
        step("pre0_turn", 2'b11, 2'b00);
        for (int c = 0; c < 16; c++) begin
            step($sformatf("pre1_%0d", c), 2'b11, 2'b10);
        end
        step("pre1_turn", 2'b11, 2'b00);
        step("pre_regrant0", 2'b11, 2'b01);

        // Asynchronous reset in the middle of an ownership
        pulseReset();
        step("async_own", 2'b10, 2'b10);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 2'b00, 8'h00, 8'h00, 8'h7E);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("async_after", 2'b00, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
